// File: rtl/sbox_streamer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sbox_streamer_pkg
// Description : Shared definitions for the S-box streamer and its receiver:
//               FSM state encoding, S-box depth, identity table and mask(i).
// Revision    : 1.0 - initial release
// ============================================================================
package sbox_streamer_pkg;

  localparam int SBOX_DEPTH = 256;

  // FSM state encoding (explicit 3-bit width)
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_INIT    = 3'd1;
  localparam state_t ST_SHUFFLE = 3'd2;
  localparam state_t ST_STREAM  = 3'd3;
  localparam state_t ST_DONE    = 3'd4;

  // Identity table S[k] = k, packed as 256 bytes with entry k at bits [8k+7:8k]
  function automatic logic [SBOX_DEPTH*8-1:0] sbox_identity();
    logic [SBOX_DEPTH*8-1:0] v;
    v = '0;
    for (int k = 0; k < SBOX_DEPTH; k++) begin
      v[k*8 +: 8] = 8'(k);
    end
    return v;
  endfunction

  localparam logic [SBOX_DEPTH-1:0][7:0] SBOX_IDENT = sbox_identity();

  // Smallest 2^n-1 that is >= i: smear the leading one into all lower bits
  function automatic logic [7:0] mask_of(input logic [7:0] i);
    logic [7:0] m;
    m = i | (i >> 1);
    m = m | (m >> 2);
    m = m | (m >> 4);
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sbox_mask.sv
`default_nettype none
// ============================================================================
// Module      : sbox_mask
// Description : Combinational candidate generation for the shuffle:
//               j = word & mask(i), accepted when j <= i.
// Revision    : 1.0 - initial release
// ============================================================================
module sbox_mask
  import sbox_streamer_pkg::*;
(
  input  logic [7:0] idx_i,
  input  logic [7:0] word_i,
  output logic [7:0] j_o,
  output logic       accept_o
);

  // Masking keeps the rejection rate below one half for any i
  assign j_o      = word_i & mask_of(idx_i);
  assign accept_o = (j_o <= idx_i);

endmodule
`default_nettype wire

// File: rtl/sbox_streamer.sv
`default_nettype none
// ============================================================================
// Module      : sbox_streamer
// Description : Builds a 256-entry S-box by a Fisher-Yates shuffle driven by
//               an external chaos word stream (with rejection sampling), then
//               streams S[0..255] to the round-function receiver.
// Revision    : 1.0 - initial release
// ============================================================================
module sbox_streamer
  import sbox_streamer_pkg::*;
#(
  parameter int CHAOS_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [CHAOS_W-1:0] chaos_data,
  input  logic               chaos_valid,
  output logic               chaos_ready,
  output logic [7:0]         sbox_out,
  output logic               sbox_valid,
  output logic               busy,
  output logic               done
);

  state_t                         state_q;
  state_t                         state_d;
  logic [SBOX_DEPTH-1:0][7:0]     s_q;
  logic [SBOX_DEPTH-1:0][7:0]     s_d;
  logic [7:0]                     i_q;
  logic [7:0]                     idx_q;
  logic [7:0]                     sbox_out_q;
  logic                           sbox_valid_q;

  logic [7:0]                     w_j;
  logic                           w_accept;
  logic                           w_swap;
  logic                           w_last;

  // Only the low byte of the chaos word is meaningful
  if (CHAOS_W > 8) begin : g_wide_chaos
    logic w_unused_hi;
    assign w_unused_hi = ^chaos_data[CHAOS_W-1:8];
  end

  sbox_mask u_mask (
    .idx_i    (i_q),
    .word_i   (chaos_data[7:0]),
    .j_o      (w_j),
    .accept_o (w_accept)
  );

  // A swap happens only on an accepted handshake; the swap at i==1 is the last
  assign w_swap = chaos_valid && chaos_ready && w_accept;
  assign w_last = w_swap && (i_q == 8'd1);

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; start is only looked at in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = ST_INIT;
      ST_INIT:    state_d = ST_SHUFFLE;
      ST_SHUFFLE: if (w_last) state_d = ST_STREAM;
      ST_STREAM:  if (idx_q == 8'd255) state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // FSM outputs decoded from the current state
  always_comb begin
    busy        = (state_q != ST_IDLE);
    chaos_ready = (state_q == ST_SHUFFLE);
    done        = (state_q == ST_DONE);
  end

  // Next S-box contents: reload identity in INIT, swap S[i] and S[j] on accept
  always_comb begin
    s_d = s_q;
    if (state_q == ST_INIT) begin
      s_d = SBOX_IDENT;
    end else if (w_swap) begin
      s_d[i_q] = s_q[w_j];
      s_d[w_j] = s_q[i_q];
    end
  end

  // S-box storage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_q <= SBOX_IDENT;
    end else begin
      s_q <= s_d;
    end
  end

  // Shuffle position i and stream position idx
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      i_q   <= 8'd255;
      idx_q <= 8'd0;
    end else if (state_q == ST_INIT) begin
      i_q   <= 8'd255;
      idx_q <= 8'd0;
    end else if (w_swap) begin
      i_q <= i_q - 8'd1;
    end else if (state_q == ST_STREAM) begin
      idx_q <= idx_q + 8'd1;
    end
  end

  // Registered stream outputs: the first byte is launched with the final swap
  // (taken from the post-swap table), later bytes one entry ahead of idx
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sbox_out_q   <= 8'd0;
      sbox_valid_q <= 1'b0;
    end else begin
      sbox_out_q   <= 8'd0;
      sbox_valid_q <= 1'b0;
      if (w_last) begin
        sbox_out_q   <= s_d[0];
        sbox_valid_q <= 1'b1;
      end else if ((state_q == ST_STREAM) && (idx_q != 8'd255)) begin
        sbox_out_q   <= s_q[idx_q + 8'd1];
        sbox_valid_q <= 1'b1;
      end
    end
  end

  assign sbox_out   = sbox_out_q;
  assign sbox_valid = sbox_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_sbox_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sbox_streamer
// Description : Directed self-checking bench for sbox_streamer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sbox_streamer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [7:0] chaos_data;
  logic       chaos_valid;
  logic       chaos_ready;
  logic [7:0] sbox_out;
  logic       sbox_valid;
  logic       busy;
  logic       done;

  sbox_streamer #(.CHAOS_W(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .chaos_data  (chaos_data),
    .chaos_valid (chaos_valid),
    .chaos_ready (chaos_ready),
    .sbox_out    (sbox_out),
    .sbox_valid  (sbox_valid),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] words[$];
  logic [7:0] got_s[256];
  logic [7:0] exp_s[256];
  int         lat;
  int         nvalid;
  int         ndone;
  int         zero_err;
  int         model_rej;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Software Fisher-Yates with the same rejection rule; returns rejected count
  function automatic int run_model();
    int         i, w, rej, m;
    logic [7:0] c, j, t;
    for (int k = 0; k < 256; k++) exp_s[k] = 8'(k);
    i = 255; w = 0; rej = 0;
    while (i >= 1) begin
      c = (w < words.size()) ? words[w] : 8'd0;
      w++;
      m = 1;
      while (m < i) m = m * 2 + 1;
      j = c & 8'(m);
      if (int'(j) <= i) begin
        t = exp_s[i]; exp_s[i] = exp_s[j]; exp_s[j] = t;
        i--;
      end else begin
        rej++;
      end
    end
    return rej;
  endfunction

  task automatic set_exp_zero_stream();
    for (int k = 0; k < 256; k++) exp_s[k] = 8'((k + 1) % 256);
  endtask

  task automatic cmp_stream(input string tag);
    int mism;
    mism = 0;
    for (int k = 0; k < 256; k++) if (got_s[k] !== exp_s[k]) mism++;
    check(tag, mism, 0);
  endtask

  // One build+stream transaction. words[] supplies the chaos stream (0 when
  // exhausted); optional stall, start pokes, and reset at stream byte abort_at.
  task automatic run_case(input bit poke, input int stall_at, input int stall_len,
                          input int abort_at);
    int cyc, widx, hs, stalled, done_cyc;
    bit hs_now;
    widx = 0; hs = 0; stalled = 0; done_cyc = 0;
    lat = -1; nvalid = 0; ndone = 0; zero_err = 0;
    @(negedge clk);
    start       = 1'b1;
    chaos_valid = 1'b1;
    chaos_data  = (words.size() > 0) ? words[0] : 8'd0;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc   = 0;
    check("init_busy", busy, 1);
    check("init_ready", chaos_ready, 0);
    while (cyc < 3000) begin
      if (stall_at >= 0 && hs == stall_at && stalled < stall_len) begin
        chaos_valid = 1'b0;
        stalled++;
      end else begin
        chaos_valid = 1'b1;
      end
      chaos_data = (widx < words.size()) ? words[widx] : 8'd0;
      start      = poke && (cyc >= 1) && (nvalid < 250) && (cyc % 5 == 0);
      hs_now     = chaos_valid && chaos_ready;
      @(posedge clk);
      cyc++;
      if (hs_now) begin
        widx++;
        hs++;
      end
      #1;
      start = 1'b0;
      if (cyc == 1) check("shuffle_ready", chaos_ready, 1);
      if (sbox_valid) begin
        if (lat < 0) lat = cyc;
        if (nvalid < 256) got_s[nvalid] = sbox_out;
        nvalid++;
      end else if (sbox_out != 8'd0) begin
        zero_err++;
      end
      if (abort_at >= 0 && nvalid == abort_at + 1) begin
        reset_n = 1'b0;
        #1;
        check("abort_out", sbox_out, 0);
        check("abort_valid", sbox_valid, 0);
        check("abort_ready", chaos_ready, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        return;
      end
      if (done) begin
        ndone++;
        done_cyc = cyc;
      end
      if (ndone > 0 && cyc >= done_cyc + 3) break;
    end
    chaos_valid = 1'b0;
  endtask

  initial begin
    reset_n     = 1'b0;
    start       = 1'b0;
    chaos_valid = 1'b0;
    chaos_data  = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out", sbox_out, 0);
    check("rst_valid", sbox_valid, 0);
    check("rst_ready", chaos_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clk) reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", busy, 0);

    // All-zero chaos: stream is 1,2,...,255,0
    words.delete();
    run_case(1'b0, -1, 0, -1);
    check("a_lat", lat, 256);
    check("a_count", nvalid, 256);
    check("a_done", ndone, 1);
    check("a_zero_when_idle", zero_err, 0);
    check("a_first", got_s[0], 1);
    check("a_last", got_s[255], 0);
    check("a_idle_after", busy, 0);
    set_exp_zero_stream();
    cmp_stream("a_stream");

    // 0xFF accepted at i=255 (no-op), 0xFF rejected at i=254, then zeros
    words.delete();
    words.push_back(8'hFF);
    words.push_back(8'hFF);
    model_rej = run_model();
    run_case(1'b0, -1, 0, -1);
    check("b_lat", lat, 257);
    check("b_count", nvalid, 256);
    check("b_s0", got_s[0], 1);
    check("b_s254", got_s[254], 0);
    check("b_s255", got_s[255], 255);
    cmp_stream("b_stream");

    // 10-cycle chaos_valid gap mid-shuffle
    words.delete();
    run_case(1'b0, 100, 10, -1);
    check("c_lat", lat, 266);
    check("c_count", nvalid, 256);
    check("c_done", ndone, 1);
    set_exp_zero_stream();
    cmp_stream("c_stream");

    // Repeated start pulses while busy
    words.delete();
    run_case(1'b1, -1, 0, -1);
    check("d_lat", lat, 256);
    check("d_count", nvalid, 256);
    check("d_done", ndone, 1);
    check("d_idle_after", busy, 0);
    cmp_stream("d_stream");

    // Reset at stream byte 100, then a fresh run must reproduce the zero stream
    words.delete();
    run_case(1'b0, -1, 0, 100);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check("e_no_resume_busy", busy, 0);
    check("e_no_resume_valid", sbox_valid, 0);
    run_case(1'b0, -1, 0, -1);
    check("e_lat", lat, 256);
    check("e_count", nvalid, 256);
    check("e_done", ndone, 1);
    set_exp_zero_stream();
    cmp_stream("e_stream");

    // Random chaos against the software model
    words.delete();
    for (int k = 0; k < 700; k++) words.push_back(8'($urandom_range(0, 255)));
    model_rej = run_model();
    run_case(1'b0, -1, 0, -1);
    check("f_lat", lat, 256 + model_rej);
    check("f_count", nvalid, 256);
    check("f_done", ndone, 1);
    cmp_stream("f_stream");
    begin
      int seen[256];
      int dups;
      dups = 0;
      for (int k = 0; k < 256; k++) seen[k] = 0;
      for (int k = 0; k < 256; k++) seen[got_s[k]]++;
      for (int k = 0; k < 256; k++) if (seen[k] != 1) dups++;
      check("f_permutation", dups, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sbox_streamer.md
SBOX_STREAMER -- requirements
Module: sbox_streamer

Interface
REQ-001 Parameter: CHAOS_W, default 8, width of the chaos input word; only bits [7:0] are used.
REQ-002 clk  input  1  single rising-edge clock.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  single-cycle request to build and transmit one S-box; sampled only in IDLE.
REQ-005 chaos_data  input  CHAOS_W  pseudo-random word from the chaotic-map generator.
REQ-006 chaos_valid  input  1  chaos_data is valid this cycle.
REQ-007 chaos_ready  output  1  block consumes chaos_data this cycle when chaos_valid is also high.
REQ-008 sbox_out  output  8  S-box byte being transmitted to the round-function receiver.
REQ-009 sbox_valid  output  1  sbox_out is valid; the receiver captures on every high cycle.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle pulse after the last byte is transmitted.

Function
REQ-012 States SHALL be IDLE, INIT, SHUFFLE, STREAM and DONE, held in a 256x8 register array S[0..255].
REQ-013 In IDLE, a start pulse SHALL move the block to INIT on the next edge; start SHALL be ignored in every other state.
REQ-014 INIT SHALL last exactly 1 cycle: it sets S[k]=k for all k, sets i=255 and moves to SHUFFLE.
REQ-015 In SHUFFLE, chaos_ready SHALL be 1; in all other states it SHALL be 0.
REQ-016 A chaos handshake SHALL be chaos_valid&&chaos_ready; the candidate is j = chaos_data[7:0] & mask(i), where mask(i) is the smallest 2^n-1 that is >= i.
REQ-017 If the candidate j<=i, S[i] and S[j] SHALL be swapped in that cycle and i decremented; j==i is a legal no-op swap.
REQ-018 If the candidate j>i, the word SHALL be consumed and discarded, with S and i unchanged.
REQ-019 If chaos_valid is low in SHUFFLE, the block SHALL stall with no state change.
REQ-020 The accepted swap at i==1 SHALL end SHUFFLE; the next state is STREAM with idx=0.
REQ-021 STREAM SHALL drive sbox_valid=1 for exactly 256 consecutive cycles, with sbox_out=S[idx] for idx = 0, 1, ..., 255 in ascending order and no gaps.
REQ-022 After idx 255 the block SHALL enter DONE. DONE SHALL assert done=1 and sbox_valid=0 for one cycle, then return to IDLE.
REQ-023 The minimum latency from the start edge to the first sbox_valid SHALL be 1 (INIT) + 255 (SHUFFLE) cycles, plus one cycle per stall or rejected word.
REQ-024 sbox_out and sbox_valid SHALL be registered outputs. sbox_out SHALL read 0 whenever sbox_valid=0.

Reset
REQ-025 Asserting reset_n low at any time, including mid-SHUFFLE or mid-STREAM, SHALL force IDLE immediately. Outputs reset to sbox_out=0, sbox_valid=0, chaos_ready=0, busy=0, done=0; i=255, idx=0, S[k]=k.
REQ-026 A stream interrupted by reset SHALL NOT resume; a new start is required.

Structure
REQ-027 State encoding, S-box depth (256) and the mask(i) function SHALL live in a shared package used by this block and the round-function receiver.
REQ-028 A single sub-module, sbox_mask, SHALL implement combinational mask(i) and j<=i acceptance; everything else is flat.

Verification
REQ-029 Reset, then pulse start and supply chaos_data=0x00 continuously. Required: sbox_valid rises 256 cycles after the start edge and the streamed bytes are 1, 2, ..., 255, 0, followed by a one-cycle done pulse.
REQ-030 Supply chaos_data=0xFF for the first word, then 0xFF again at i=254, then 0x00 for all remaining words. Required: the second 0xFF is rejected (i stays 254) and first-valid latency grows by exactly 1 cycle.
REQ-031 Drop chaos_valid low for 10 cycles mid-SHUFFLE. Required: no S or i change during the gap, and first-valid latency grows by exactly 10 cycles.
REQ-032 Pulse start repeatedly during SHUFFLE and STREAM. Required: no effect; exactly 256 sbox_valid cycles and one done pulse.
REQ-033 Assert reset_n low at stream byte 100. Required: all outputs 0 within the reset cycle; a fresh start with the 0x00 stream reproduces the REQ-029 sequence.
REQ-034 Feed random chaos. Required: the 256 streamed bytes form a permutation of 0..255, and the result matches a software Fisher-Yates model using the same rejection rule.
